// File: rtl/antilog_seq_pkg.sv
// Shared widths and FSM encodings for the log-domain units (log2 / antilog) and their benches.
package antilog_seq_pkg;

  localparam int unsigned ANTILOG_EXP_W  = 3;
  localparam int unsigned ANTILOG_FRAC_W = 5;
  localparam int unsigned ANTILOG_OUT_W  = 1 << ANTILOG_EXP_W;
  localparam int unsigned ANTILOG_ACC_W  = ANTILOG_FRAC_W + ANTILOG_OUT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/antilog_seq.sv
// Iterative Mitchell antilog: value = ((2^FRAC_W + frac) << exp) >> FRAC_W, one shift per clock.
module antilog_seq
  import antilog_seq_pkg::*;
#(
  parameter int unsigned EXP_W  = ANTILOG_EXP_W,
  parameter int unsigned FRAC_W = ANTILOG_FRAC_W,
  parameter int unsigned OUT_W  = 2 ** EXP_W  // derived; do not override
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W-1:0] in_frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_value
);

  localparam int unsigned ACC_W = FRAC_W + OUT_W;

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [EXP_W-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            acc <= {{(ACC_W-FRAC_W-1){1'b0}}, 1'b1, in_frac};
            cnt <= in_exp;
          end
        end
        ST_SHIFT: begin
          acc <= acc << 1;
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_value = '0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nxt = (in_exp != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (cnt == EXP_W'(1))
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        // Integer part of the fixed-point accumulator; fraction bits are truncated.
        out_value = acc[FRAC_W +: OUT_W];
        if (out_ready)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
